multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore FSM control unit that sequences a multicycle RV32I-subset datapath: unified instr/data memory, a single ALU reused for PC+4, branch target and address.
- Replaces the single-cycle controller when the core moves to the shared-memory multicycle datapath.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.
- Drives register/memory write enables, mux selects and ALUControl from the latched instruction and the ALU Zero flag.

Parameters:
- STATE_W, 4, width of the state register; must hold 11 states.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  Instr[6:0] from the instruction register.
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- Zero  in  1  ALU result == 0.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  latches the instruction register and OldPC.
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data register, 10 ALUResult.
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 RD1 register.
- ALUSrcB  out  2  ALU B select: 00 WriteData register, 01 ImmExt, 10 constant 4.
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- RegWrite  out  1  register file write enable.
- InstrDone  out  1  one-cycle pulse in the final state of each retired instruction.

Behaviour:
- Reset:
  - State is forced asynchronously to FETCH.
  - While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and InstrDone are forced to 0.
  - All other outputs take their FETCH values.
- Outputs are a pure function of the state, except as follows:
  - ImmSrc is decoded from op: lw/I-type/default 00, sw 01, beq 10, jal 11.
  - ALUControl comes from ALUOp plus funct3/funct7b5.
  - PCWrite = PCUpdate | (Branch & Zero).
- Every signal not listed for a state is 0; every select not listed is 00.
- States and actions (an arrow means next state):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
    - lw or sw -> MEMADR.
    - R-type -> EXECR.
    - I-type -> EXECI.
    - jal -> JAL.
    - beq -> BEQ.
    - any other op -> FETCH, with no writes and no InstrDone.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, InstrDone=1 -> FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1 -> FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, InstrDone=1 -> FETCH.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000 -> sub if (funct7b5 & op[5]), else add.
    - 010 -> slt.
    - 110 -> or.
    - 111 -> and.
    - anything else -> add.
- Latency in cycles, FETCH through the last state: lw 5; sw, R-type, I-type, jal 4; beq 3; illegal op 2.
- Zero is sampled only in BEQ; it is ignored in all other states.
- Reset asserted mid-instruction aborts it immediately: no further writes, and the FSM restarts at FETCH after release.
- An unreachable state encoding goes to FETCH on the next edge, with all enables 0.

Optional Feature:
- Macro: MULTICYCLE_BNE_EN.
- Defined: in BEQ the branch condition is Zero ^ (funct3==001), so opcode 1100011 with funct3 001 implements bne.
- Undefined: funct3 is ignored in BEQ, and every 1100011 branch behaves as beq.

Decomposition:
- Shared package holds:
  - state encodings;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - ALUOp, ALUControl, ImmSrc, ResultSrc and ALUSrcA/B encodings.
- One sub-module: multicycle_aludec (ALUOp/funct3/funct7b5/op[5] -> ALUControl, combinational).
- The FSM and the instruction decoder stay in multicycle_ctrl.

Test Plan:
- Reset: assert reset mid-MEMADR -> state FETCH immediately and all enables 0; after release, FETCH has IRWrite=1, PCWrite=1, ALUSrcB=10.
- lw (op 0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. MEMREAD has AdrSrc=1; MEMWB has RegWrite=1, ResultSrc=01, InstrDone=1 on cycle 5.
- sw (op 0100011): MemWrite=1 only in cycle 4, with AdrSrc=1 and ImmSrc=01; RegWrite stays 0 throughout.
- R-type sub (op 0110011, funct3 000, funct7b5 1): EXECR gives ALUControl=001; with funct7b5=0 it gives 000. addi with funct7b5=1 gives 000. funct3 010 gives 101.
- beq (op 1100011), cycle 3: Zero=1 -> PCWrite=1; Zero=0 -> PCWrite=0. With MULTICYCLE_BNE_EN defined and funct3=001, the result is inverted.
- jal (op 1101111): JAL state gives PCWrite=1, ALUSrcA=01, ImmSrc=11; RegWrite=1 in cycle 4. Illegal op 1111111: back in FETCH after 2 cycles with no InstrDone.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
//
// Shared definitions for the multicycle RV32I-subset control unit:
//   - FSM state encodings (11 states, 4 bits)
//   - opcode constants for the supported instruction classes
//   - ALUOp, ALUControl, ImmSrc, ResultSrc and ALUSrcA/B encodings
//
// No ports; imported by multicycle_ctrl and multicycle_aludec.
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    // Opcodes (Instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALUOp: what the FSM asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl: what the ALU actually does
    localparam logic [2:0] ALUCTL_ADD = 3'b000;
    localparam logic [2:0] ALUCTL_SUB = 3'b001;
    localparam logic [2:0] ALUCTL_AND = 3'b010;
    localparam logic [2:0] ALUCTL_OR  = 3'b011;
    localparam logic [2:0] ALUCTL_SLT = 3'b101;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU B mux
    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_aludec.sv
// -----------------------------------------------------------------------------
// multicycle_aludec
//
// Combinational ALU decoder: turns the FSM's ALUOp plus instruction fields
// into the 3-bit ALUControl.
//
// Ports:
//   alu_op     in  2  ALUOp from the FSM (00 add, 01 sub, 10 by funct3)
//   funct3     in  3  Instr[14:12]
//   funct7b5   in  1  Instr[30]
//   op5        in  1  Instr[5]; distinguishes R-type (1) from I-type (0)
//   alu_control out 3 ALU operation
// -----------------------------------------------------------------------------
module multicycle_aludec
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALUCTL_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALUCTL_ADD;
            ALUOP_SUB: alu_control = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type sub sets funct7b5; for addi bit 30 is
                    // part of the immediate and must not select sub.
                    3'b000:  alu_control = (funct7b5 & op5) ? ALUCTL_SUB : ALUCTL_ADD;
                    3'b010:  alu_control = ALUCTL_SLT;
                    3'b110:  alu_control = ALUCTL_OR;
                    3'b111:  alu_control = ALUCTL_AND;
                    default: alu_control = ALUCTL_ADD;
                endcase
            end
            default: alu_control = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Moore FSM control unit for a multicycle RV32I-subset datapath with a shared
// instruction/data memory and one ALU (used for PC+4, branch target and
// address). Supports lw, sw, R-type, I-type ALU, beq and jal.
//
// Build option: define MULTICYCLE_BNE_EN to make funct3==001 in the branch
// state invert the Zero condition (bne). Without it every 1100011 branch is
// treated as beq.
//
// Ports:
//   clk        in   1  core clock, rising edge
//   reset      in   1  asynchronous, active-high reset
//   op         in   7  Instr[6:0]
//   funct3     in   3  Instr[14:12]
//   funct7b5   in   1  Instr[30]
//   Zero       in   1  ALU result == 0 (only looked at in BEQ)
//   PCWrite    out  1  PC enable
//   AdrSrc     out  1  memory address: 0 PC, 1 ALUOut
//   MemWrite   out  1  memory write enable
//   IRWrite    out  1  instruction register / OldPC enable
//   ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    out  2  00 PC, 01 OldPC, 10 RD1
//   ALUSrcB    out  2  00 WriteData, 01 ImmExt, 10 constant 4
//   ImmSrc     out  2  00 I, 01 S, 10 B, 11 J
//   ALUControl out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//   RegWrite   out  1  register file write enable
//   InstrDone  out  1  pulse in the last state of a retired instruction
//   state_dbg  out  STATE_W  current FSM state (debug/observation only)
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int STATE_W = 4   // must be >= 4 to hold the 11 states
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               RegWrite,
    output logic               InstrDone,
    output logic [STATE_W-1:0] state_dbg
);

    state_t state, next_state;

    // Raw per-state controls, before reset gating
    logic       pc_update;
    logic       branch;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       done_raw;
    logic [1:0] alu_op;
    logic       branch_taken;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // ------------------------------------------------------------------
    // Next state and per-state outputs
    // ------------------------------------------------------------------
    always_comb begin
        next_state    = S_FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        done_raw      = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = ALUOP_ADD;

        case (state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                alu_op       = ALUOP_ADD;
                ResultSrc    = RES_ALURESULT;
                pc_update    = 1'b1;
                next_state   = S_DECODE;
            end
            S_DECODE: begin
                // Branch target OldPC+imm is parked in ALUOut here.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_JAL:       next_state = S_JAL;
                    OP_BEQ:       next_state = S_BEQ;
                    default:      next_state = S_FETCH; // illegal: silently drop
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_ADD;
                if (op == OP_LW)      next_state = S_MEMREAD;
                else if (op == OP_SW) next_state = S_MEMWRITE;
                else                  next_state = S_FETCH;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                ResultSrc  = RES_ALUOUT;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                next_state    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                ResultSrc     = RES_ALUOUT;
                mem_write_raw = 1'b1;
                done_raw      = 1'b1;
                next_state    = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_WD;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_JAL: begin
                // OldPC+4 becomes the link value; PC takes the target from ALUOut.
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                ResultSrc  = RES_ALUOUT;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc     = RES_ALUOUT;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                next_state    = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_WD;
                alu_op     = ALUOP_SUB;
                ResultSrc  = RES_ALUOUT;
                branch     = 1'b1;
                done_raw   = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                // Unreachable encodings: all enables stay 0, recover to FETCH.
                next_state = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Branch condition
    // ------------------------------------------------------------------
`ifdef MULTICYCLE_BNE_EN
    assign branch_taken = Zero ^ (funct3 == 3'b001);
`else
    assign branch_taken = Zero;
`endif

    // ------------------------------------------------------------------
    // Instruction-dependent decodes
    // ------------------------------------------------------------------
    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    multicycle_aludec u_aludec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

    // ------------------------------------------------------------------
    // Enables are gated by reset so no write escapes while it is held,
    // even though the state is already FETCH (whose enables are 1).
    // ------------------------------------------------------------------
    assign PCWrite   = ~reset & (pc_update | (branch & branch_taken));
    assign IRWrite   = ~reset & ir_write_raw;
    assign RegWrite  = ~reset & reg_write_raw;
    assign MemWrite  = ~reset & mem_write_raw;
    assign InstrDone = ~reset & done_raw;

    assign state_dbg = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl: directed, self-checking bench for multicycle_ctrl.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .InstrDone  (InstrDone),
        .state_dbg  (state_dbg)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and checker
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Advance one cycle and sample away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
        #1;
    endtask

    // State plus the four write-type enables in one go.
    task automatic check_cyc(input string tag, input logic [3:0] st,
                             input logic pcw, input logic regw,
                             input logic memw, input logic done);
        check({tag, ".state"},     8'(state_dbg), 8'(st));
        check({tag, ".PCWrite"},   8'(PCWrite),   8'(pcw));
        check({tag, ".RegWrite"},  8'(RegWrite),  8'(regw));
        check({tag, ".MemWrite"},  8'(MemWrite),  8'(memw));
        check({tag, ".InstrDone"}, 8'(InstrDone), 8'(done));
    endtask

    // Runs an R/I-type ALU instruction from FETCH, checking ALUControl in exec.
    task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [3:0] exec_st, input logic [2:0] exp_ctl);
        set_instr(o, f3, f7, 1'b0);
        tick();
        check_cyc({tag, ".dec"}, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_cyc({tag, ".exe"}, exec_st, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, ".ALUControl"}, 8'(ALUControl), 8'(exp_ctl));
        check({tag, ".ALUSrcA"},    8'(ALUSrcA),    8'd2);
        tick();
        check_cyc({tag, ".wb"}, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1);
        check({tag, ".ResultSrc"}, 8'(ResultSrc), 8'd0);
        tick();
        check_cyc({tag, ".fetch"}, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Branch from FETCH; expects the PCWrite value in the BEQ state.
    task automatic run_br(input string tag, input logic [2:0] f3, input logic z, input logic exp_pcw);
        set_instr(7'b1100011, f3, 1'b0, z);
        tick();
        // Zero must not matter outside BEQ.
        check_cyc({tag, ".dec"}, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_cyc({tag, ".beq"}, 4'd10, exp_pcw, 1'b0, 1'b0, 1'b1);
        check({tag, ".ALUControl"}, 8'(ALUControl), 8'd1);
        check({tag, ".ImmSrc"},     8'(ImmSrc),     8'd2);
        tick();
        check_cyc({tag, ".fetch"}, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset held: FETCH state, enables forced low, FETCH selects.
        #2;
        check_cyc("rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst.IRWrite",   8'(IRWrite),   8'd0);
        check("rst.ALUSrcB",   8'(ALUSrcB),   8'd2);
        check("rst.ResultSrc", 8'(ResultSrc), 8'd2);

        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_cyc("fetch0", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fetch0.IRWrite", 8'(IRWrite), 8'd1);
        check("fetch0.AdrSrc",  8'(AdrSrc),  8'd0);

        // lw: 5 cycles
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b1);
        tick();
        check_cyc("lw.dec", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lw.dec.ALUSrcA", 8'(ALUSrcA), 8'd1);
        check("lw.dec.ALUSrcB", 8'(ALUSrcB), 8'd1);
        tick();
        check_cyc("lw.adr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lw.adr.ALUSrcA", 8'(ALUSrcA), 8'd2);
        tick();
        check_cyc("lw.rd", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lw.rd.AdrSrc", 8'(AdrSrc), 8'd1);
        tick();
        check_cyc("lw.wb", 4'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        check("lw.wb.ResultSrc", 8'(ResultSrc), 8'd1);
        tick();
        check_cyc("lw.fetch", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // sw: 4 cycles
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        tick();
        check_cyc("sw.dec", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_cyc("sw.adr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_cyc("sw.wr", 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        check("sw.wr.AdrSrc", 8'(AdrSrc), 8'd1);
        check("sw.wr.ImmSrc", 8'(ImmSrc), 8'd1);
        tick();
        check_cyc("sw.fetch", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // ALU decode cases
        run_alu("sub",  7'b0110011, 3'b000, 1'b1, 4'd6, 3'b001);
        run_alu("add",  7'b0110011, 3'b000, 1'b0, 4'd6, 3'b000);
        run_alu("slt",  7'b0110011, 3'b010, 1'b0, 4'd6, 3'b101);
        run_alu("or",   7'b0110011, 3'b110, 1'b0, 4'd6, 3'b011);
        run_alu("and",  7'b0110011, 3'b111, 1'b0, 4'd6, 3'b010);
        run_alu("addi", 7'b0010011, 3'b000, 1'b1, 4'd7, 3'b000);
        run_alu("slti", 7'b0010011, 3'b010, 1'b0, 4'd7, 3'b101);
        run_alu("xor",  7'b0110011, 3'b100, 1'b0, 4'd6, 3'b000);

        // Branches
        run_br("beq.z1", 3'b000, 1'b1, 1'b1);
        run_br("beq.z0", 3'b000, 1'b0, 1'b0);
`ifdef MULTICYCLE_BNE_EN
        run_br("bne.z1", 3'b001, 1'b1, 1'b0);
        run_br("bne.z0", 3'b001, 1'b0, 1'b1);
`else
        run_br("bne.z1", 3'b001, 1'b1, 1'b1);
        run_br("bne.z0", 3'b001, 1'b0, 1'b0);
`endif

        // jal: 4 cycles
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        tick();
        check_cyc("jal.dec", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_cyc("jal.jal", 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        check("jal.ALUSrcA", 8'(ALUSrcA), 8'd1);
        check("jal.ALUSrcB", 8'(ALUSrcB), 8'd2);
        check("jal.ImmSrc",  8'(ImmSrc),  8'd3);
        tick();
        check_cyc("jal.wb", 4'd9, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check_cyc("jal.fetch", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Illegal op: DECODE then straight back to FETCH, nothing retired
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b1);
        tick();
        check_cyc("ill.dec", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_cyc("ill.fetch", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ill.fetch.IRWrite", 8'(IRWrite), 8'd1);

        // Reset mid-MEMADR
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        tick();
        tick();
        check_cyc("rst2.adr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_cyc("rst2.held", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst2.IRWrite", 8'(IRWrite), 8'd0);
        tick();
        check_cyc("rst2.held2", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_cyc("rst2.fetch", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst2.fetch.IRWrite", 8'(IRWrite), 8'd1);
        check("rst2.fetch.ALUSrcB", 8'(ALUSrcB), 8'd2);
        tick();
        check_cyc("rst2.dec", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // ------------------------------------------------------------------
        // Final report
        // ------------------------------------------------------------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
